window_v_gen_fp16: RTL and testbench
====================================

WINDOW_V_GEN_FP16 -- requirements
Module: window_v_gen_fp16

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5, FP exponent bits.
REQ-002 SHALL have parameter FRAC_WIDTH, default 10, FP fraction bits.
REQ-003 SHALL have parameter FP_WIDTH_REG, default 1+FRAC_WIDTH+EXP_WIDTH, pixel word width.
REQ-004 SHALL have parameter WINDOW_HEIGHT, default 3, odd and >=3, vertical window size.
REQ-005 SHALL have parameter IMAGE_WIDTH, default 640, pixels per line, 2..65535.
REQ-006 SHALL have port clk_i, input, 1, sole clock, all logic rising-edge.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port data_i, input, FP_WIDTH_REG, raster-order pixel.
REQ-009 SHALL have ports col_i and row_i, input, 16 each, pixel coordinates.
REQ-010 SHALL have port valid_i, input, 1, data_i/col_i/row_i qualifier; no backpressure.
REQ-011 SHALL have port window_o, output, FP_WIDTH_REG x [WINDOW_HEIGHT][1], vertical column window.
REQ-012 SHALL have ports col_o and row_o, output, 16 each, window-centre coordinates.
REQ-013 SHALL have port valid_o, output, 1, window_o/col_o/row_o qualifier.
REQ-014 SHALL have port col_err_o, output, 1, sticky flag: col_i >= IMAGE_WIDTH seen.

Function
REQ-015 SHALL store WINDOW_HEIGHT-1 previous lines, each IMAGE_WIDTH words, addressed by col_i.
REQ-016 On valid_i with col_i < IMAGE_WIDTH, line k SHALL read address col_i and write line k+1's old value; the newest line SHALL write data_i (shift-up per column).
REQ-017 window_o[0][0] SHALL be the oldest row (row_i-(H-1)); window_o[H-1][0] SHALL be data_i.
REQ-018 Latency SHALL be exactly 1 cycle valid_i -> valid_o; all outputs registered.
REQ-019 Row-fill counter SHALL count completed lines (valid_i with col_i == IMAGE_WIDTH-1), saturating at WINDOW_HEIGHT-1.
REQ-020 valid_o SHALL assert only for a valid in-range input accepted while the row-fill counter == WINDOW_HEIGHT-1; otherwise it SHALL be 0.
REQ-021 valid_i with col_i==0 and row_i==0 SHALL start a new frame: counter cleared to 0 in the same cycle, that pixel still written; no window output for it.
REQ-022 col_o SHALL equal col_i; row_o SHALL equal row_i - (WINDOW_HEIGHT-1)/2, modulo 2^16.
REQ-023 col_i >= IMAGE_WIDTH with valid_i SHALL: not write buffers, not change the counter, valid_o=0, set col_err_o.
REQ-024 Cycles without valid_i SHALL change no state; valid_o SHALL be 0.
REQ-025 window_o/col_o/row_o SHALL hold their last value while valid_o=0.
REQ-026 No top/bottom padding; the first H-1 rows of each frame produce no output.

Reset
REQ-027 On rst_i: valid_o=0, window_o all zero, col_o=0, row_o=0, col_err_o=0, counter=0.
REQ-028 Line-buffer contents SHALL NOT be reset; stale data is never emitted because the counter restarts at 0.
REQ-029 rst_i mid-frame SHALL suppress output until H-1 further complete lines have been accepted.

Structure
REQ-030 EXP_WIDTH/FRAC_WIDTH fp16 defaults and FP_WIDTH_REG derivation SHALL live in the shared floating-point package.
REQ-031 One sub-module, line_buffer_ram (single-port, read-before-write, depth IMAGE_WIDTH), SHALL be instantiated WINDOW_HEIGHT-1 times.
REQ-032 window_o SHALL connect directly to convolution_floating_point window_i for any WINDOW_HEIGHT x 1 kernel.

Verification
REQ-033 IMAGE_WIDTH=4, H=3, frame 4x4 with pixel=fp16(row*4+col), continuous valid -> first valid_o cycle after (row2,col0) input; window {0,4,8}, row_o=1, col_o=0; 8 valid_o pulses total.
REQ-034 Same frame with valid_i deasserted every other cycle -> identical window sequence; valid_o pulses 1 cycle after each accepted pixel only.
REQ-035 rst_i for 1 cycle after row2 col1 -> valid_o=0 through rows 2 and 3; next frame's row2 col0 again yields {0,4,8}.
REQ-036 Inject valid pixel col_i=5 mid-row2 -> col_err_o=1 stays set, valid_o=0 that cycle, subsequent windows unchanged.
REQ-037 New frame (row0,col0) arriving after only row 1 complete -> no valid_o until new frame's row 2.
REQ-038 End-to-end: chain into box_v fp16 convolution, ramp frame -> data_o equals vertical 3-tap mean within 1 ulp.

Source files
------------

// File: rtl/window_v_gen_fp16_pkg.sv
// window_v_gen_fp16_pkg: shared fp16 format constants and pixel word width helper
package window_v_gen_fp16_pkg;
    localparam int FP16_EXP_WIDTH  = 5;
    localparam int FP16_FRAC_WIDTH = 10;
    function automatic int fp_width(input int exp_width, input int frac_width);
        return 1 + frac_width + exp_width;
    endfunction
endpackage

// File: rtl/window_v_gen_fp16_line_buffer_ram.sv
// line_buffer_ram: single-port line store, combinational read of the old word alongside a clocked write
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : word address (column)
//   wdata_i : word written at addr_i on the rising edge
//   rdata_o : word currently stored at addr_i (pre-write value)
module line_buffer_ram
    import window_v_gen_fp16_pkg::*;
#(
    parameter int WIDTH = fp_width(FP16_EXP_WIDTH, FP16_FRAC_WIDTH),
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign rdata_o = mem[addr_i];
    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end
endmodule

// File: rtl/window_v_gen_fp16.sv
// window_v_gen_fp16: WINDOW_HEIGHT x 1 vertical pixel window generator over a raster stream
//   clk_i, rst_i        : clock, synchronous active-high reset
//   data_i/col_i/row_i  : raster pixel and its coordinates, qualified by valid_i
//   window_o[k][0]      : k=0 oldest row .. k=WINDOW_HEIGHT-1 current row
//   col_o/row_o         : window centre coordinates, qualified by valid_o
//   col_err_o           : sticky, set when a valid pixel arrives with col_i >= IMAGE_WIDTH
module window_v_gen_fp16
    import window_v_gen_fp16_pkg::*;
#(
    parameter int EXP_WIDTH     = FP16_EXP_WIDTH,
    parameter int FRAC_WIDTH    = FP16_FRAC_WIDTH,
    parameter int FP_WIDTH_REG  = fp_width(EXP_WIDTH, FRAC_WIDTH),
    parameter int WINDOW_HEIGHT = 3,
    parameter int IMAGE_WIDTH   = 640
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,
    output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][1],
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o,
    output logic                    col_err_o
);
    localparam int AW = $clog2(IMAGE_WIDTH);
    localparam int CW = $clog2(WINDOW_HEIGHT);
    localparam logic [CW-1:0] FULL     = CW'(WINDOW_HEIGHT - 1);
    localparam logic [15:0]   LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0]   HALF     = 16'((WINDOW_HEIGHT - 1) / 2);

    logic [CW-1:0]           fill_cnt;
    logic [FP_WIDTH_REG-1:0] tap [WINDOW_HEIGHT];
    logic                    in_range, accept, new_frame, full, fire;

    assign in_range  = col_i <= LAST_COL;
    assign accept    = valid_i && in_range;
    assign new_frame = col_i == 16'd0 && row_i == 16'd0;
    assign full      = fill_cnt == FULL;
    assign fire      = accept && !new_frame && full;

    // tap[k] is line k's stored word at col_i; the top tap is the live pixel, so
    // each line writes its younger neighbour's old value and the column shifts up.
    assign tap[WINDOW_HEIGHT-1] = data_i;
    for (genvar k = 0; k < WINDOW_HEIGHT - 1; k++) begin : g_line
        line_buffer_ram #(
            .WIDTH(FP_WIDTH_REG),
            .DEPTH(IMAGE_WIDTH),
            .AW   (AW)
        ) u_line (
            .clk_i  (clk_i),
            .we_i   (accept),
            .addr_i (col_i[AW-1:0]),
            .wdata_i(tap[k+1]),
            .rdata_o(tap[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            col_o     <= '0;
            row_o     <= '0;
            col_err_o <= 1'b0;
            fill_cnt  <= '0;
            for (int i = 0; i < WINDOW_HEIGHT; i++) window_o[i][0] <= '0;
        end else begin
            valid_o <= fire;
            if (valid_i && !in_range) col_err_o <= 1'b1;
            if (accept) fill_cnt <= new_frame ? '0 : (col_i == LAST_COL && !full) ? fill_cnt + 1'b1 : fill_cnt;
            if (fire) begin
                for (int i = 0; i < WINDOW_HEIGHT; i++) window_o[i][0] <= tap[i];
                col_o <= col_i;
                row_o <= row_i - HALF;
            end
        end
    end
endmodule

// File: tb/tb_window_v_gen_fp16.sv
// tb_window_v_gen_fp16: directed checks of the vertical window generator on a 4x4 fp16 ramp frame
module tb_window_v_gen_fp16;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [15:0] col_i = '0;
    logic [15:0] row_i = '0;
    logic [15:0] window_o [3][1];
    logic [15:0] col_o, row_o;
    logic        valid_o, col_err_o;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pulses = 0;
    logic [15:0] last_w [3];
    logic [15:0] last_col, last_row;
    // fp16 encodings of the integers 0..15
    logic [15:0] fp [16] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200,
                             16'h4400, 16'h4500, 16'h4600, 16'h4700,
                             16'h4800, 16'h4880, 16'h4900, 16'h4980,
                             16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80};

    window_v_gen_fp16 #(
        .WINDOW_HEIGHT(3),
        .IMAGE_WIDTH  (4)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .col_i    (col_i),
        .row_i    (row_i),
        .valid_i  (valid_i),
        .window_o (window_o),
        .col_o    (col_o),
        .row_o    (row_o),
        .valid_o  (valid_o),
        .col_err_o(col_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outputs(input string tag, input bit exp_valid);
        check({tag, " valid"}, 32'(valid_o), 32'(exp_valid));
        if (exp_valid) pulses++;
        check({tag, " w0"}, 32'(window_o[0][0]), 32'(last_w[0]));
        check({tag, " w1"}, 32'(window_o[1][0]), 32'(last_w[1]));
        check({tag, " w2"}, 32'(window_o[2][0]), 32'(last_w[2]));
        check({tag, " col"}, 32'(col_o), 32'(last_col));
        check({tag, " row"}, 32'(row_o), 32'(last_row));
    endtask

    task automatic pixel(input int r, input int c, input bit exp_valid);
        row_i   = 16'(r);
        col_i   = 16'(c);
        data_i  = (c < 4) ? fp[r*4+c] : 16'hDEAD;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        if (exp_valid) begin
            last_w[0] = fp[(r-2)*4+c];
            last_w[1] = fp[(r-1)*4+c];
            last_w[2] = fp[r*4+c];
            last_col  = 16'(c);
            last_row  = 16'(r - 1);
        end
        check_outputs($sformatf("px r%0d c%0d", r, c), exp_valid);
    endtask

    task automatic idle();
        valid_i = 1'b0;
        data_i  = 16'($urandom);
        col_i   = 16'($urandom_range(0, 3));
        row_i   = 16'($urandom_range(0, 3));
        @(posedge clk_i);
        #1;
        check_outputs("idle", 1'b0);
    endtask

    task automatic frame(input bit gaps);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                pixel(r, c, r >= 2);
                if (gaps) idle();
            end
    endtask

    task automatic clear_expect();
        for (int i = 0; i < 3; i++) last_w[i] = '0;
        last_col = '0;
        last_row = '0;
    endtask

    initial begin
        clear_expect();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_outputs("reset", 1'b0);
        check("reset col_err", 32'(col_err_o), 32'd0);

        pulses = 0;
        frame(1'b0);
        check("pulses continuous", 32'(pulses), 32'd8);

        pulses = 0;
        frame(1'b1);
        check("pulses gapped", 32'(pulses), 32'd8);

        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) pixel(r, c, 1'b0);
        pixel(2, 0, 1'b1);
        pixel(2, 1, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        clear_expect();
        check_outputs("midframe reset", 1'b0);
        pixel(2, 2, 1'b0);
        pixel(2, 3, 1'b0);
        for (int c = 0; c < 4; c++) pixel(3, c, 1'b0);
        pulses = 0;
        frame(1'b0);
        check("pulses after reset", 32'(pulses), 32'd8);

        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) pixel(r, c, 1'b0);
        pixel(2, 0, 1'b1);
        pixel(2, 1, 1'b1);
        check("col_err before", 32'(col_err_o), 32'd0);
        pixel(2, 5, 1'b0);
        check("col_err set", 32'(col_err_o), 32'd1);
        pixel(2, 2, 1'b1);
        pixel(2, 3, 1'b1);
        for (int c = 0; c < 4; c++) pixel(3, c, 1'b1);

        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) pixel(r, c, 1'b0);
        pulses = 0;
        frame(1'b0);
        check("pulses restarted frame", 32'(pulses), 32'd8);
        check("col_err sticky", 32'(col_err_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
